// File: rtl/toom8_eval_seq.sv
`default_nettype none
// ============================================================================
// Module   : toom8_eval_seq
// Brief    : Splits a 1024-bit operand into eight limbs and evaluates the
//            degree-7 limb polynomial at the 15 Toom-8 points, streaming one
//            signed result per point over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module toom8_eval_seq #(
    parameter int LIMB_W = 128,
    parameter int ACC_W  = 145,
    parameter int OUT_W  = 156
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*LIMB_W-1:0]     in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_idx,
    output logic                    out_last,
    output logic signed [OUT_W-1:0] out_val
);

    localparam int         N_LIMBS  = 8;
    localparam logic [3:0] IDX_LAST = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PT_INIT = 2'd1,
        S_EVAL    = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t                  r_state;
    logic [LIMB_W-1:0]       r_limb [N_LIMBS];
    logic [3:0]              r_idx;
    logic [2:0]              r_step;
    logic signed [ACC_W-1:0] r_acc;

    function automatic logic signed [3:0] point_p(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd5, 4'd9, 4'd13: point_p = 4'sd1;
            4'd2, 4'd6, 4'd10:       point_p = -4'sd1;
            4'd3:                    point_p = 4'sd2;
            4'd4:                    point_p = -4'sd2;
            4'd7:                    point_p = 4'sd3;
            4'd8:                    point_p = -4'sd3;
            4'd11:                   point_p = 4'sd4;
            4'd12:                   point_p = -4'sd4;
            default:                 point_p = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [3:0] point_q(input logic [3:0] idx);
        case (idx)
            4'd5, 4'd6:  point_q = 4'sd2;
            4'd9, 4'd10: point_q = 4'sd3;
            4'd13:       point_q = 4'sd4;
            default:     point_q = 4'sd1;
        endcase
    endfunction

    logic signed [3:0]       w_p;
    logic signed [3:0]       w_q;
    logic signed [3:0]       w_mult;
    logic                    w_rev;
    logic                    w_neg_term;
    logic [2:0]              w_j;
    logic [3:0]              w_mag;
    logic signed [ACC_W-1:0] w_mag_acc;
    logic signed [ACC_W-1:0] w_scaled;
    logic signed [ACC_W-1:0] w_limb_ext;
    logic signed [ACC_W-1:0] w_acc_eval;
    logic signed [ACC_W-1:0] w_init_val;
    logic signed [ACC_W-1:0] w_load_val;
    logic signed [OUT_W-1:0] w_out_val;

    // Points with q>1 all have p=+-1, so they run Horner from a0 upward
    // (acc*q + a_j*p^j); q=1 points run from a7 downward (acc*p + a_j).
    // Either way every step is a multiply by a constant in -4..4 plus a
    // signed limb add, and the sum equals sum a_i*p^i*q^(7-i).
    always_comb begin
        w_p        = point_p(r_idx);
        w_q        = point_q(r_idx);
        w_rev      = (w_q != 4'sd1);
        w_mult     = w_rev ? w_q : w_p;
        w_j        = w_rev ? (3'd7 - r_step) : r_step;
        w_neg_term = w_rev && w_p[3] && w_j[0];
        w_mag      = w_mult[3] ? unsigned'(-w_mult) : unsigned'(w_mult);

        case (w_mag)
            4'd1:    w_mag_acc = r_acc;
            4'd2:    w_mag_acc = r_acc <<< 1;
            4'd3:    w_mag_acc = (r_acc <<< 1) + r_acc;
            4'd4:    w_mag_acc = r_acc <<< 2;
            default: w_mag_acc = '0;
        endcase

        w_scaled   = w_mult[3] ? -w_mag_acc : w_mag_acc;
        w_limb_ext = signed'({{(ACC_W-LIMB_W){1'b0}}, r_limb[w_j]});
        w_acc_eval = w_neg_term ? (w_scaled - w_limb_ext) : (w_scaled + w_limb_ext);

        w_init_val = signed'({{(ACC_W-LIMB_W){1'b0}},
                              ((r_idx == 4'd0) || w_rev) ? r_limb[0] : r_limb[N_LIMBS-1]});
        w_load_val = (r_state == S_EVAL) ? w_acc_eval : w_init_val;
        w_out_val  = {{(OUT_W-ACC_W){w_load_val[ACC_W-1]}}, w_load_val};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
            out_val   <= '0;
            r_idx     <= 4'd0;
            r_step    <= 3'd0;
            r_acc     <= '0;
            for (int i = 0; i < N_LIMBS; i++) begin
                r_limb[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N_LIMBS; i++) begin
                            r_limb[i] <= in_op[i*LIMB_W +: LIMB_W];
                        end
                        r_idx    <= 4'd0;
                        in_ready <= 1'b0;
                        r_state  <= S_PT_INIT;
                    end
                end

                S_PT_INIT: begin
                    r_acc  <= w_init_val;
                    r_step <= 3'd6;
                    if ((r_idx == 4'd0) || (r_idx == IDX_LAST)) begin
                        out_valid <= 1'b1;
                        out_idx   <= r_idx;
                        out_last  <= (r_idx == IDX_LAST);
                        out_val   <= w_out_val;
                        r_state   <= S_OUT;
                    end else begin
                        r_state <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    r_acc <= w_acc_eval;
                    if (r_step == 3'd0) begin
                        out_valid <= 1'b1;
                        out_idx   <= r_idx;
                        out_last  <= 1'b0;
                        out_val   <= w_out_val;
                        r_state   <= S_OUT;
                    end else begin
                        r_step <= r_step - 3'd1;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            in_ready <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_PT_INIT;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toom8_eval_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_toom8_eval_seq
// Brief    : Self-checking bench for toom8_eval_seq (vector table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_toom8_eval_seq;

    localparam int LIMB_W = 128;
    localparam int ACC_W  = 145;
    localparam int OUT_W  = 156;
    localparam int N_VEC  = 10;
    localparam int PT_P [15] = '{0, 1, -1, 2, -2, 1, -1, 3, -3, 1, -1, 4, -4, 1, 0};
    localparam int PT_Q [15] = '{1, 1, 1, 1, 1, 2, 2, 1, 1, 3, 3, 1, 1, 4, 1};

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [8*LIMB_W-1:0]     in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              out_idx;
    logic                    out_last;
    logic signed [OUT_W-1:0] out_val;

    toom8_eval_seq #(.LIMB_W(LIMB_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_val   (out_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                      sel;
        int                      idx;
        logic signed [OUT_W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]              idx;
        logic signed [OUT_W-1:0] val;
    } exp_t;

    vec_t                    vt [N_VEC];
    exp_t                    sb [$];
    logic signed [OUT_W-1:0] cap_val [15];
    int                      n_checks = 0;
    int                      n_errors = 0;

    // Direct sum of a_i * p^i * q^(7-i), no Horner.
    function automatic logic signed [OUT_W-1:0] model(input logic [8*LIMB_W-1:0] op, input int idx);
        logic signed [OUT_W-1:0] sum, term, ps, qs;
        if (idx == 0)  return OUT_W'(op[LIMB_W-1:0]);
        if (idx == 14) return OUT_W'(op[7*LIMB_W +: LIMB_W]);
        ps  = OUT_W'(PT_P[idx]);
        qs  = OUT_W'(PT_Q[idx]);
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            term = OUT_W'(op[i*LIMB_W +: LIMB_W]);
            for (int k = 0; k < i; k++)     term = term * ps;
            for (int k = 0; k < 7 - i; k++) term = term * qs;
            sum = sum + term;
        end
        return sum;
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [8*LIMB_W-1:0] op);
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            e.idx = 4'(i);
            e.val = model(op, i);
            sb.push_back(e);
        end
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 15; i++) cap_val[i] = 'x;
    endtask

    task automatic send(input logic [8*LIMB_W-1:0] op);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_ready", OUT_W'(in_ready), OUT_W'(1));
        in_op    = op;
        in_valid = 1'b1;
        push_expected(op);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_outstanding", OUT_W'(sb.size()), OUT_W'(0));
    endtask

    task automatic check_table(input int sel);
        for (int i = 0; i < N_VEC; i++) begin
            if (vt[i].sel == sel)
                check($sformatf("vec%0d_idx%0d", i, vt[i].idx), cap_val[vt[i].idx], vt[i].exp);
        end
    endtask

    task automatic wait_out_idx(input logic [3:0] idx);
        int t = 0;
        while (!(out_valid && out_idx == idx) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check($sformatf("reach_idx%0d", idx), OUT_W'(out_valid && out_idx == idx), OUT_W'(1));
    endtask

    initial begin
        logic [8*LIMB_W-1:0]     op1, op0, op3, opr;
        logic [LIMB_W-1:0]       ones;
        logic signed [OUT_W-1:0] mx;
        logic                    seen;

        ones = '1;
        mx   = OUT_W'(ones);
        op0  = '0;
        op3  = '1;
        for (int i = 0; i < 8; i++) op1[i*LIMB_W +: LIMB_W] = LIMB_W'(i + 1);

        vt[0] = '{1, 0,  OUT_W'(1)};
        vt[1] = '{1, 1,  OUT_W'(36)};
        vt[2] = '{1, 2,  -OUT_W'(4)};
        vt[3] = '{1, 3,  OUT_W'(1793)};
        vt[4] = '{1, 5,  OUT_W'(502)};
        vt[5] = '{1, 14, OUT_W'(8)};
        vt[6] = '{3, 2,  OUT_W'(0)};
        vt[7] = '{3, 11, mx * OUT_W'(21845)};
        vt[8] = '{3, 12, -(mx * OUT_W'(13107))};
        vt[9] = '{3, 14, mx};

        clear_cap();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        out_ready = 1'b1;

        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_output: got idx %0d, expected no output", out_idx);
                        end else begin
                            e = sb.pop_front();
                            check("out_idx", OUT_W'(out_idx), OUT_W'(e.idx));
                            check($sformatf("out_val_idx%0d", e.idx), out_val, e.val);
                            check("out_last", OUT_W'(out_last), OUT_W'(e.idx == 4'd14));
                            cap_val[out_idx] = out_val;
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
        check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("rst_out_idx",   OUT_W'(out_idx),   OUT_W'(0));
        check("rst_out_last",  OUT_W'(out_last),  OUT_W'(0));
        check("rst_out_val",   out_val,           OUT_W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ascending limbs, no backpressure
        clear_cap();
        send(op1);
        wait_drain(400);
        check_table(1);

        // All-zero operand with latency checks
        send(op0);
        check("lat_pt_init_valid", OUT_W'(out_valid), OUT_W'(0));
        @(posedge clk); #1;
        check("lat_first_valid", OUT_W'(out_valid), OUT_W'(1));
        check("lat_first_idx",   OUT_W'(out_idx),   OUT_W'(0));
        repeat (119) @(posedge clk);
        #1;
        check("lat_busy_120", OUT_W'(in_ready), OUT_W'(0));
        @(posedge clk); #1;
        check("lat_ready_121", OUT_W'(in_ready), OUT_W'(1));
        check("zero_sb_empty", OUT_W'(sb.size()), OUT_W'(0));

        // All-ones operand: extreme magnitudes
        clear_cap();
        send(op3);
        wait_drain(400);
        check_table(3);

        // Stall on idx7
        for (int k = 0; k < 32; k++) opr[k*32 +: 32] = $urandom();
        send(opr);
        wait_out_idx(4'd7);
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_valid", OUT_W'(out_valid), OUT_W'(1));
            check("stall_idx",   OUT_W'(out_idx),   OUT_W'(7));
            check("stall_val",   out_val,           model(opr, 7));
        end
        out_ready = 1'b1;
        wait_drain(400);

        // Reset during EVAL of idx4
        send(op3);
        wait_out_idx(4'd3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  OUT_W'(in_ready),  OUT_W'(1));
        check("midrst_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("midrst_out_idx",   OUT_W'(out_idx),   OUT_W'(0));
        check("midrst_out_last",  OUT_W'(out_last),  OUT_W'(0));
        check("midrst_out_val",   out_val,           OUT_W'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", OUT_W'(seen), OUT_W'(0));
        clear_cap();
        send(op1);
        wait_drain(400);
        check_table(1);

        // in_valid held high with another operand while busy
        clear_cap();
        send(op1);
        in_op    = op3;
        in_valid = 1'b1;
        push_expected(op3);
        begin
            int t = 0;
            while (!in_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("busy_ready_back", OUT_W'(in_ready), OUT_W'(1));
        check("busy_pending",    OUT_W'(sb.size()), OUT_W'(15));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain(400);
        check_table(3);

        // Random operand with random backpressure
        for (int k = 0; k < 32; k++) opr[k*32 +: 32] = $urandom();
        send(opr);
        begin
            int t = 0;
            while (sb.size() != 0 && t < 2000) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                t++;
            end
        end
        out_ready = 1'b1;
        wait_drain(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
